bit_stream_serializer: RTL and testbench
========================================

Name: bit_stream_serializer

Overview:
- Upstream feeder for the single-bit sequence-detector FSM: accepts parallel words over a valid/ready handshake and drives them out one bit per clock on a serial line.
- The serial line connects directly to the detector's serial input `i`. `bit_valid` qualifies each bit for the bench and scoreboards.
- Optional inter-frame gap holds the line at an idle level between words, so detector behaviour on idle input is deterministic.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB first.
- GAP_CYCLES, 2, idle cycles inserted after each frame; legal range 0..15.
- IDLE_LEVEL, 1, value driven on bit_out whenever no frame bit is being driven.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  parallel word; sampled only on a handshake
- in_valid  input  1  upstream holds word valid
- in_ready  output  1  block can accept a word this cycle (combinational from state/counter)
- bit_out  output  1  serial bit stream to the detector input (registered)
- bit_valid  output  1  high while bit_out carries a frame bit (registered)
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame (registered)
- busy  output  1  high in SHIFT or GAP (combinational from state)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: rst is sampled at the clk edge. Next state is IDLE, shift register is 0, counters are 0, bit_out=IDLE_LEVEL, bit_valid=0, frame_done=0.
- While rst is high, in_ready=0. Reset mid-frame or mid-gap aborts immediately and discards the word; no frame_done is generated.
- Handshake: a transfer occurs on a clk edge where in_valid && in_ready && !rst. Only then is in_data sampled; in_data is don't-care otherwise.
- States:
  - IDLE (2'b00)
  - SHIFT (2'b01)
  - GAP (2'b11)
- IDLE:
  - in_ready=1, bit_out=IDLE_LEVEL, bit_valid=0.
  - On transfer: load the shift register, set bit_cnt=0, go to SHIFT.
- Latency: a transfer at edge T puts frame bit 0 on bit_out in the cycle after T. Bit k appears in cycle T+1+k.
- SHIFT:
  - bit_valid=1. Each edge advances one bit: MSB-first shifts left and uses bit[WIDTH-1]; LSB-first shifts right and uses bit[0].
  - bit_cnt counts 0..FRAME_LEN-1, where FRAME_LEN=WIDTH, or WIDTH+1 with the option below. Counter width is clog2(FRAME_LEN+1).
  - frame_done=1 only in the cycle bit_cnt==FRAME_LEN-1.
  - After the last bit: go to GAP if GAP_CYCLES>0, otherwise to IDLE.
- Back-to-back (GAP_CYCLES==0 only):
  - in_ready=1 during the last-bit cycle of SHIFT.
  - A transfer then reloads the shift register and stays in SHIFT with bit_cnt=0, so the new frame's bit 0 follows with no bubble and bit_valid stays high.
- GAP:
  - bit_out=IDLE_LEVEL, bit_valid=0, in_ready=0.
  - gap_cnt counts GAP_CYCLES cycles, then the block returns to IDLE.
  - in_valid held high during GAP is not accepted until IDLE.
- Timing summary: last bit in cycle T+FRAME_LEN; gap occupies T+FRAME_LEN+1 .. T+FRAME_LEN+GAP_CYCLES; IDLE (in_ready=1) from T+FRAME_LEN+GAP_CYCLES+1.
- in_ready is 0 in SHIFT except in the back-to-back case above.
- Simultaneous events: rst has priority over a transfer and over frame completion.
- No other states are reachable. Unused encoding 2'b10 goes to IDLE.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined: FRAME_LEN=WIDTH+1. After the data bits, one even-parity bit (XOR-reduction of the captured word) is driven with bit_valid=1. frame_done moves to the parity-bit cycle.
- Undefined: FRAME_LEN=WIDTH. No parity logic is present, and timing is as specified without it.

Test Plan:
- Defaults, rst for 2 cycles, transfer 8'b1011_0010 at edge T -> bit_out 1,0,1,1,0,0,1,0 in cycles T+1..T+8 with bit_valid=1; frame_done only at T+8; bit_out=1, bit_valid=0 at T+9..T+10; in_ready=1 at T+11.
- in_valid held high through SHIFT/GAP while in_data changes -> only the word present at the IDLE handshake is serialized; the second word starts exactly one cycle after in_ready rises.
- GAP_CYCLES=0, words 8'hA5 then 8'h3C offered continuously -> 16 consecutive bit_valid=1 cycles carrying 1010_0101_0011_1100; frame_done at bits 8 and 16.
- rst asserted for 1 cycle after the 3rd bit of 8'hFF -> next cycle bit_valid=0, bit_out=1, no frame_done; in_ready=1 once rst low; a new word serializes correctly.
- LSB_FIRST=1, word 8'h01 -> bit_out 1,0,0,0,0,0,0,0.
- SERIALIZER_PARITY_EN defined: 8'hA5 -> 9 bits ending 0, frame_done on bit 9; 8'h07 -> ninth bit 1; in_ready returns at T+12.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel word to serial bit stream with handshake and optional inter-frame gap.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_stream_serializer #(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 0,
    parameter int GAP_CYCLES = 2,
    parameter int IDLE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] PEN = CW'(FRAME_LEN - 2);
    localparam logic [3:0] GAP_LAST = GAP_CYCLES == 0 ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);
    localparam bit LSB = LSB_FIRST != 0;

    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, GAP = 2'b11} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             xfer;
    logic             ld_bit;
    logic [WIDTH-1:0] ld_sreg;
    logic             nxt_bit;
    logic [WIDTH-1:0] nxt_sreg;

    assign in_ready = !rst && (state == IDLE || (GAP_CYCLES == 0 && state == SHIFT && bit_cnt == LAST));
    assign busy     = state == SHIFT || state == GAP;
    assign xfer     = in_valid && in_ready;
    assign ld_bit   = LSB ? in_data[0] : in_data[WIDTH-1];
    assign ld_sreg  = LSB ? in_data >> 1 : in_data << 1;
    assign nxt_sreg = LSB ? sreg >> 1 : sreg << 1;

`ifdef SERIALIZER_PARITY_EN
    logic par;
    // After the last data bit the parity of the captured word goes out instead of the shift register.
    assign nxt_bit = bit_cnt == CW'(WIDTH - 1) ? par : (LSB ? sreg[0] : sreg[WIDTH-1]);
    always_ff @(posedge clk) begin
        if (rst)
            par <= 1'b0;
        else if (xfer)
            par <= ^in_data;
    end
`else
    assign nxt_bit = LSB ? sreg[0] : sreg[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            bit_out    <= IDLE_BIT;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (xfer) begin
            state      <= SHIFT;
            sreg       <= ld_sreg;
            bit_cnt    <= '0;
            bit_out    <= ld_bit;
            bit_valid  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_out    <= IDLE_BIT;
                    bit_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
                SHIFT: begin
                    if (bit_cnt == LAST) begin
                        state      <= GAP_CYCLES > 0 ? GAP : IDLE;
                        gap_cnt    <= '0;
                        bit_out    <= IDLE_BIT;
                        bit_valid  <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        sreg       <= nxt_sreg;
                        bit_cnt    <= bit_cnt + CW'(1);
                        bit_out    <= nxt_bit;
                        frame_done <= bit_cnt == PEN;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    state   <= gap_cnt == GAP_LAST ? IDLE : GAP;
                end
                default: begin
                    state      <= IDLE;
                    bit_out    <= IDLE_BIT;
                    bit_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: directed checks of the serializer with default, zero-gap and LSB-first instances.
module tb_bit_stream_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       r0, b0, bv0, fd0, busy0;
    logic       r1, b1, bv1, fd1, busy1;
    logic       r2, b2, bv2, fd2, busy2;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    bit_stream_serializer u0 (.clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .bit_out(b0), .bit_valid(bv0), .frame_done(fd0), .busy(busy0));
    bit_stream_serializer #(.GAP_CYCLES(0)) u1 (.clk(clk), .rst(rst), .in_data(d1), .in_valid(v1),
        .in_ready(r1), .bit_out(b1), .bit_valid(bv1), .frame_done(fd1), .busy(busy1));
    bit_stream_serializer #(.LSB_FIRST(1)) u2 (.clk(clk), .rst(rst), .in_data(d2), .in_valid(v2),
        .in_ready(r2), .bit_out(b2), .bit_valid(bv2), .frame_done(fd2), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int k, input bit lsb);
        if (k >= 8)
            return ^w;
        return lsb ? w[k] : w[7-k];
    endfunction

    // Entered one cycle after the transfer edge; leaves u0 in the first IDLE cycle after the gap.
    task automatic frame0(input logic [7:0] w);
        for (int k = 0; k < FL; k++) begin
            check($sformatf("u0 bit%0d", k), b0, exp_bit(w, k, 0));
            check("u0 bit_valid", bv0, 1);
            check("u0 frame_done", fd0, k == FL - 1);
            check("u0 ready in shift", r0, 0);
            d0 = 8'($urandom);
            step;
        end
        for (int g = 0; g < 2; g++) begin
            check("u0 gap bit_out", b0, 1);
            check("u0 gap bit_valid", bv0, 0);
            check("u0 gap ready", r0, 0);
            check("u0 gap busy", busy0, 1);
            step;
        end
        check("u0 ready after gap", r0, 1);
        check("u0 busy after gap", busy0, 0);
    endtask

    initial begin
        step;
        step;
        check("rst bit_out", b0, 1);
        check("rst bit_valid", bv0, 0);
        check("rst frame_done", fd0, 0);
        check("rst ready", r0, 0);
        check("rst busy", busy0, 0);
        check("rst ready u1", r1, 0);
        rst = 1'b0;
        #1;
        check("ready after rst", r0, 1);
        d0 = 8'b1011_0010;
        v0 = 1'b1;
        step;
        v0 = 1'b0;
        frame0(8'b1011_0010);
        d0 = 8'h5A;
        v0 = 1'b1;
        step;
        frame0(8'h5A);
        d0 = 8'hC3;
        step;
        v0 = 1'b0;
        frame0(8'hC3);
        d0 = 8'hFF;
        v0 = 1'b1;
        step;
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("ff bit", b0, 1);
            check("ff bit_valid", bv0, 1);
            if (k < 2)
                step;
        end
        rst = 1'b1;
        #1;
        check("ready during rst", r0, 0);
        step;
        check("abort bit_valid", bv0, 0);
        check("abort bit_out", b0, 1);
        check("abort frame_done", fd0, 0);
        check("abort busy", busy0, 0);
        rst = 1'b0;
        #1;
        check("ready after abort", r0, 1);
        d0 = 8'h96;
        v0 = 1'b1;
        step;
        v0 = 1'b0;
        frame0(8'h96);
        d0 = 8'h07;
        v0 = 1'b1;
        step;
        v0 = 1'b0;
        frame0(8'h07);
        d1 = 8'hA5;
        v1 = 1'b1;
        step;
        d1 = 8'h3C;
        for (int k = 0; k < 2 * FL; k++) begin
            check($sformatf("b2b bit%0d", k), b1, k < FL ? exp_bit(8'hA5, k, 0) : exp_bit(8'h3C, k - FL, 0));
            check("b2b bit_valid", bv1, 1);
            check("b2b frame_done", fd1, k == FL - 1 || k == 2 * FL - 1);
            check("b2b ready", r1, k == FL - 1 || k == 2 * FL - 1);
            step;
            if (k == FL - 1)
                v1 = 1'b0;
        end
        check("b2b end bit_valid", bv1, 0);
        check("b2b end bit_out", b1, 1);
        check("b2b end ready", r1, 1);
        d2 = 8'h01;
        v2 = 1'b1;
        step;
        v2 = 1'b0;
        for (int k = 0; k < FL; k++) begin
            check($sformatf("lsb bit%0d", k), b2, exp_bit(8'h01, k, 1));
            check("lsb bit_valid", bv2, 1);
            check("lsb frame_done", fd2, k == FL - 1);
            step;
        end
        check("lsb gap bit_valid", bv2, 0);
        check("lsb gap busy", busy2, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
